// File: rtl/zdos_trap_pkg.sv
// Shared definitions for the DOS entry/exit trap: FSM encodings and the
// default address-high byte of the Beta-disk entry point.
package zdos_trap_pkg;

  typedef enum logic [1:0] {
    ZT_IDLE  = 2'd0,
    ZT_FETCH = 2'd1,
    ZT_DONE  = 2'd2
  } zt_state_e;

  localparam logic [7:0] ZT_TRAP_HI_DEF = 8'h3D;

endpackage

// File: rtl/zdos_trap_if.sv
// Z80 bus strobes, mapping state and DOS flag pulses seen by the trap.
interface zdos_trap_if;
  logic [15:0] za;
  logic        m1_n;
  logic        mreq_n;
  logic        rfsh_n;
  logic        romnram;
  logic        rom48;
  logic        dos;
  logic        trap_en;
  logic        dos_turn_on;
  logic        dos_turn_off;
  logic        fetch_active;

  modport master (
    output za, m1_n, mreq_n, rfsh_n, romnram, rom48, dos, trap_en,
    input  dos_turn_on, dos_turn_off, fetch_active
  );

  modport slave (
    input  za, m1_n, mreq_n, rfsh_n, romnram, rom48, dos, trap_en,
    output dos_turn_on, dos_turn_off, fetch_active
  );
endinterface

// File: rtl/zdos_trap_zsync.sv
// Multi-flop synchronizer for an active-low Z80 strobe; resets to the
// inactive (high) level so no false strobe is seen after reset.
module zsync_n #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/zdos_trap.sv
// Watches Z80 M1 fetches and emits single-cycle DOS turn-on (entry trap at
// TRAP_HI page of BASIC48 ROM) and turn-off (fetch from RAM) pulses.
module zdos_trap
  import zdos_trap_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TRAP_HI     = ZT_TRAP_HI_DEF,
  parameter int         TMO_W       = 6
) (
  input  logic        fclk,
  input  logic        rst_n,
  zdos_trap_if.slave  bus
);

  logic m1_s, mreq_s, rfsh_s;

  zsync_n #(.STAGES(SYNC_STAGES)) u_sync_m1   (.clk_i(fclk), .rst_ni(rst_n), .d_i(bus.m1_n),   .q_o(m1_s));
  zsync_n #(.STAGES(SYNC_STAGES)) u_sync_mreq (.clk_i(fclk), .rst_ni(rst_n), .d_i(bus.mreq_n), .q_o(mreq_s));
  zsync_n #(.STAGES(SYNC_STAGES)) u_sync_rfsh (.clk_i(fclk), .rst_ni(rst_n), .d_i(bus.rfsh_n), .q_o(rfsh_s));

  zt_state_e        state_q, state_d;
  logic             mreq_prev_q;
  logic [7:0]       za_hi_q, za_hi_d;
  logic             romnram_q, romnram_d;
  logic             rom48_q, rom48_d;
  logic             pend_off_q, pend_off_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             turn_on, turn_off;

  // Edge qualified: a still-low MREQ after a finished fetch cannot restart it.
  logic fetch_start, on_hit, off_arm;
  assign fetch_start = !m1_s && !mreq_s && rfsh_s && mreq_prev_q;
  assign on_hit      = bus.trap_en && !bus.dos && romnram_q && rom48_q && (za_hi_q == TRAP_HI);
  assign off_arm     = bus.dos && !romnram_q;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ZT_IDLE;
      mreq_prev_q <= 1'b1;
      za_hi_q     <= '0;
      romnram_q   <= 1'b0;
      rom48_q     <= 1'b0;
      pend_off_q  <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mreq_prev_q <= mreq_s;
      za_hi_q     <= za_hi_d;
      romnram_q   <= romnram_d;
      rom48_q     <= rom48_d;
      pend_off_q  <= pend_off_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    za_hi_d    = za_hi_q;
    romnram_d  = romnram_q;
    rom48_d    = rom48_q;
    pend_off_d = pend_off_q;
    tmo_d      = '0;
    turn_on    = 1'b0;
    turn_off   = 1'b0;
    unique case (state_q)
      ZT_IDLE: begin
        if (fetch_start) begin
          state_d    = ZT_FETCH;
          za_hi_d    = bus.za[15:8];
          romnram_d  = bus.romnram;
          rom48_d    = bus.rom48;
          pend_off_d = 1'b0;
        end
      end
      ZT_FETCH: begin
        // The first FETCH cycle (watchdog still zero) is the single decision point.
        if (tmo_q == '0) begin
          turn_on = on_hit;
          if (off_arm) pend_off_d = 1'b1;
        end
        if (mreq_s) begin
          state_d = ZT_DONE;
        end else if (&tmo_q) begin
          state_d    = ZT_DONE;
          pend_off_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ZT_DONE: begin
        turn_off   = pend_off_q;
        pend_off_d = 1'b0;
        state_d    = ZT_IDLE;
      end
      default: state_d = ZT_IDLE;
    endcase
  end

  assign bus.dos_turn_on  = turn_on;
  assign bus.dos_turn_off = turn_off;
  assign bus.fetch_active = (state_q == ZT_FETCH);

endmodule
